// File: rtl/mil_word_transmitter_pkg.sv
// Shared MIL-STD-1553 word definitions: word type, MilData layout, sync patterns
// and the 40 half-bit line frame built from one word.
package mil_word_transmitter_pkg;

    typedef enum logic [1:0] {
        WSTATUS  = 2'd0,
        WCOMMAND = 2'd1,
        WDATA    = 2'd2,
        WERROR   = 2'd3
    } data_type_e;

    typedef struct packed {
        data_type_e  data_type;
        logic [15:0] data_word;
    } mil_data_t;

    localparam logic [5:0] SYNC_CS   = 6'b111000;
    localparam logic [5:0] SYNC_DATA = 6'b000111;

    // Frame bit 39 goes on the line first: sync, Manchester data MSB first, odd parity.
    function automatic logic [39:0] mil_frame(input mil_data_t d);
        logic [39:0] f;
        f[39:34] = (d.data_type == WDATA) ? SYNC_DATA : SYNC_CS;
        for (int i = 0; i < 16; i++) begin
            f[2*i+3] = d.data_word[i];
            f[2*i+2] = ~d.data_word[i];
        end
        f[1] = ~^d.data_word;
        f[0] = ^d.data_word;
        return f;
    endfunction

endpackage

// File: rtl/mil_word_transmitter_halfbit_timer.sv
// Free-running half-bit timer; tick marks the last clock of each half-bit,
// restart realigns the half-bit grid to the next clock.
module mil_halfbit_timer #(
    parameter int HALF_BIT_CLKS = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(HALF_BIT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mil_word_transmitter.sv
// Manchester-II serialiser for 1553 words: one-deep holding register feeding a
// 40 half-bit shift register; back-to-back words leave no gap on the line.
module mil_word_transmitter
    import mil_word_transmitter_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 50,
    parameter int GAP_HALF_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_request,
    input  logic [17:0] in_data,
    output logic        ready,
    output logic        accepted,
    output logic        rejected,
    output logic        mil_tx,
    output logic        mil_ntx,
    output logic        isBusy
);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_e;

    localparam int GW = (GAP_HALF_BITS > 1) ? $clog2(GAP_HALF_BITS) : 1;

    state_e          state, state_d;
    logic [5:0]      hcnt, hcnt_d;
    logic [GW-1:0]   gcnt, gcnt_d;
    logic            hold_full;
    mil_data_t       hold, req;
    logic [39:0]     shreg;
    logic            tick, pop, restart, active, wdata_ok, take;

    mil_halfbit_timer #(.HALF_BIT_CLKS(HALF_BIT_CLKS)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign req      = mil_data_t'(in_data);
    assign active   = (state == SYNC) || (state == DATA) || (state == PARITY);
    // A data word needs a word already on the line ahead of it.
    assign wdata_ok = (state != IDLE) && (state != GAP);
    // A pop in the same cycle frees the holding register for this request.
    assign take     = in_request && (!hold_full || pop) && (req.data_type != WERROR)
                      && ((req.data_type != WDATA) || wdata_ok);

    assign ready    = ~hold_full;
    assign isBusy   = (state != IDLE) || hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hcnt  <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_d;
            hcnt  <= hcnt_d;
            gcnt  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        gcnt_d  = gcnt;
        pop     = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_d = SYNC;
                    hcnt_d  = '0;
                    pop     = 1'b1;
                    restart = 1'b1;
                end
            end
            SYNC, DATA, PARITY: begin
                if (tick) begin
                    if (hcnt == 6'd39) begin
                        hcnt_d = '0;
                        if (hold_full) begin
                            state_d = SYNC;
                            pop     = 1'b1;
                        end else begin
                            state_d = GAP;
                            gcnt_d  = '0;
                        end
                    end else begin
                        hcnt_d = hcnt + 6'd1;
                        if (hcnt == 6'd5)
                            state_d = DATA;
                        else if (hcnt == 6'd37)
                            state_d = PARITY;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gcnt == GW'(GAP_HALF_BITS - 1))
                        state_d = IDLE;
                    else
                        gcnt_d = gcnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold      <= '0;
            accepted  <= 1'b0;
            rejected  <= 1'b0;
        end else begin
            accepted <= take;
            rejected <= in_request && !take;
            if (take) begin
                hold_full <= 1'b1;
                hold      <= req;
            end else if (pop) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Line outputs lag the shift register by one clock, so a word appears two
    // clocks after its accepting edge and contiguous words keep the same grid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            mil_tx  <= 1'b0;
            mil_ntx <= 1'b0;
        end else begin
            if (pop)
                shreg <= mil_frame(hold);
            else if (tick && active)
                shreg <= {shreg[38:0], 1'b0};
            mil_tx  <= active & shreg[39];
            mil_ntx <= active & ~shreg[39];
        end
    end

endmodule
